pipe_latch: RTL and testbench
=============================

# pipe_latch

Parametrised, handshaked pipeline-stage register that replaces the fixed-field, flush-only inter-stage latches (IF/ID, ID/EX, …) with one generic block. It carries an arbitrary-width payload with valid/ready flow control and a 2-entry skid buffer so `in_ready` is registered. It supports a synchronous flush that squashes in-flight entries, drives a configurable NOP value whenever it is empty, and keeps saturating stall and flush counters for performance debug. One instance sits between each pair of adjacent pipeline stages.

## Interface
Parameters:
- `WIDTH`, 64 — payload width in bits (e.g. instruction + PC+4).
- `NOP`, `WIDTH'(0)` — value driven on `dout` whenever `out_valid` = 0.
- `CNT_W`, 16 — width of each performance counter.

Ports:
- `CLK`  in  1  — clock; all state updates on the rising edge.
- `RST`  in  1  — synchronous, active-high reset.
- `in_valid`  in  1  — upstream stage presents `din`.
- `in_ready`  out  1  — latch can accept; registered.
- `din`  in  `WIDTH`  — payload from the upstream stage.
- `flush`  in  1  — squash all held entries; driven by the hazard/branch unit.
- `out_valid`  out  1  — `dout` holds a live entry; registered.
- `out_ready`  in  1  — downstream stage consumes `dout`.
- `dout`  out  `WIDTH`  — payload to the downstream stage.
- `stall_cnt`  out  `CNT_W`  — count of back-pressure cycles.
- `flush_cnt`  out  `CNT_W`  — count of flushes that killed live data.

## Operation
- Storage: main register (`main_v`, `main_d`) and skid register (`skid_v`, `skid_d`).
- `accept` = `in_valid & in_ready`; `emit` = `out_valid & out_ready`.
- Output mapping:
  - `out_valid` = `main_v`.
  - `dout` = `main_d` when `main_v`, else `NOP`.
  - `in_ready` = `!skid_v`.
- States: EMPTY (no valid entries), FULL (`main_v` only), SKID (`main_v` and `skid_v`). No other encoding is legal.
- EMPTY: `accept` → FULL, main ← `din`.
- FULL:
  - `accept & emit` → FULL, main ← `din`.
  - `accept & !emit` → SKID, skid ← `din`.
  - `!accept & emit` → EMPTY.
  - otherwise hold.
- SKID: `in_ready` = 0, so no accept occurs. `emit` → FULL, main ← skid, skid cleared; otherwise hold.
- Flush has highest priority:
  - Next state is EMPTY regardless of `accept`/`emit`; any `din` accepted in the flush cycle is discarded.
  - An `emit` in the flush cycle is still a completed transfer; downstream owns that entry.
- Data registers need no reset; they are don't-care while their valid bit is 0.
- `stall_cnt`: +1 each cycle with `out_valid & !out_ready`.
- `flush_cnt`: +1 each cycle with `flush & (main_v | skid_v)`.
- Both counters saturate at 2^`CNT_W`−1 and clear only on reset.
- Reset (`RST` = 1 at an edge): EMPTY, so `out_valid` = 0, `in_ready` = 1, `dout` = `NOP`, both counters 0. Reset overrides flush and all transfers.

## Timing
- Latency: `din` accepted at edge N appears on `dout` with `out_valid` = 1 after edge N (one cycle).
- Throughput: one transfer per cycle in steady state with `out_ready` = 1.
- Back-pressure: `out_ready` low while FULL still accepts one more beat (into skid). `in_ready` falls one cycle later and rises the cycle after the next `emit`.
- No combinational path from `out_ready` or `flush` to `in_ready`, `out_valid` or `dout`.
- Flush asserted at edge N: `out_valid` = 0 and `in_ready` = 1 after N. A new accept is possible in cycle N+1.
- Simultaneous reset and flush: reset result, and `flush_cnt` is not incremented.

## Test plan
- Reset, then stream `din` = 1..8 with `in_valid` = 1, `out_ready` = 1 → `dout` = 1..8 on consecutive cycles, one cycle after each accept; `stall_cnt` = 0.
- Fill to FULL with A, drop `out_ready`, present B → B accepted into skid; `in_ready` = 0 next cycle. Raise `out_ready` → A then B emitted in order, no loss or duplicate; `stall_cnt` = number of low cycles with A valid.
- SKID state, assert `flush` with `in_valid` = 1 → next cycle `out_valid` = 0, `dout` = `NOP` (test with `NOP` = 0x0000_0000_0000_0000), `in_ready` = 1, `flush_cnt` = 1.
- `flush` while EMPTY → no state change, `flush_cnt` unchanged.
- `CNT_W` = 4, hold `out_ready` = 0 for 20 cycles with a valid entry → `stall_cnt` stops at 15.
- `RST` asserted mid-stream together with `flush`, `in_valid`, `out_ready` → next cycle all outputs at reset values and both counters 0.

Source files
------------

// File: rtl/pipe_latch_if.sv
// Handshake bundle between two adjacent pipeline stages, as seen by one pipe_latch.
// The master modport is the latch side; the slave modport is the stage side driving it.
interface pipe_latch_if #(
   parameter int unsigned WIDTH = 64
);
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] din;
   logic             flush;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] dout;

   modport master (
      input  in_valid,
      output in_ready,
      input  din,
      input  flush,
      output out_valid,
      input  out_ready,
      output dout
   );

   modport slave (
      output in_valid,
      input  in_ready,
      output din,
      output flush,
      input  out_valid,
      output out_ready,
      input  dout
   );
endinterface

// File: rtl/pipe_latch.sv
// Generic handshaked pipeline-stage register with a 2-entry skid buffer, flush,
// NOP output when empty and saturating stall/flush performance counters.
module pipe_latch #(
   parameter int unsigned     WIDTH = 64,
   parameter logic [WIDTH-1:0] NOP  = WIDTH'(0),
   parameter int unsigned     CNT_W = 16
) (
   input  logic             CLK,
   input  logic             RST,
   pipe_latch_if.master     bus,
   output logic [CNT_W-1:0] stall_cnt,
   output logic [CNT_W-1:0] flush_cnt
);

   typedef enum logic [1:0] {StEmpty, StFull, StSkid} state_e;

   state_e           state_q, state_d;
   logic [WIDTH-1:0] main_data_q, main_data_d;
   logic [WIDTH-1:0] skid_data_q, skid_data_d;
   logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
   logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

   logic main_v, skid_v, accept, emit;

   // All handshake outputs come straight from state, so no comb path from out_ready/flush.
   assign main_v        = (state_q == StFull) || (state_q == StSkid);
   assign skid_v        = (state_q == StSkid);
   assign bus.out_valid = main_v;
   assign bus.in_ready  = !skid_v;
   assign bus.dout      = main_v ? main_data_q : NOP;
   assign stall_cnt     = stall_cnt_q;
   assign flush_cnt     = flush_cnt_q;

   assign accept = bus.in_valid && !skid_v;
   assign emit   = main_v && bus.out_ready;

   always_comb begin
      state_d     = state_q;
      main_data_d = main_data_q;
      skid_data_d = skid_data_q;
      unique case (state_q)
         StEmpty: begin
            if (accept) begin
               state_d     = StFull;
               main_data_d = bus.din;
            end
         end
         StFull: begin
            if (accept && emit) begin
               main_data_d = bus.din;
            end else if (accept) begin
               state_d     = StSkid;
               skid_data_d = bus.din;
            end else if (emit) begin
               state_d = StEmpty;
            end
         end
         StSkid: begin
            if (emit) begin
               state_d     = StFull;
               main_data_d = skid_data_q;
            end
         end
         default: state_d = StEmpty;
      endcase
      if (bus.flush) begin
         state_d = StEmpty;
      end
   end

   always_comb begin
      stall_cnt_d = stall_cnt_q;
      flush_cnt_d = flush_cnt_q;
      if (main_v && !bus.out_ready && !(&stall_cnt_q)) begin
         stall_cnt_d = stall_cnt_q + CNT_W'(1);
      end
      if (bus.flush && (main_v || skid_v) && !(&flush_cnt_q)) begin
         flush_cnt_d = flush_cnt_q + CNT_W'(1);
      end
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q     <= StEmpty;
         stall_cnt_q <= '0;
         flush_cnt_q <= '0;
      end else begin
         state_q     <= state_d;
         stall_cnt_q <= stall_cnt_d;
         flush_cnt_q <= flush_cnt_d;
      end
   end

   // Payload registers are qualified by the valid bits and need no reset.
   always_ff @(posedge CLK) begin
      main_data_q <= main_data_d;
      skid_data_q <= skid_data_d;
   end

endmodule

// File: tb/tb_pipe_latch.sv
// Self-checking bench for pipe_latch: directed scenarios plus random traffic,
// compared against a queue-based model of the held entries.
module tb_pipe_latch;

   localparam logic [63:0] NOP16 = 64'h0;
   localparam logic [63:0] NOP4  = 64'hDEAD_BEEF_0BAD_F00D;

   logic        clk = 1'b0;
   logic        rst;
   logic [15:0] stall16, flush16;
   logic [3:0]  stall4, flush4;

   int n_checks = 0;
   int n_errors = 0;

   // Model: held entries oldest first, plus counters per instance width.
   logic [63:0] mq[$];
   int          m_stall16, m_flush16, m_stall4, m_flush4;

   always #5 clk = ~clk;

   pipe_latch_if #(.WIDTH(64)) if16 ();
   pipe_latch_if #(.WIDTH(64)) if4 ();

   pipe_latch #(.WIDTH(64), .NOP(NOP16), .CNT_W(16)) u_dut16 (
      .CLK       (clk),
      .RST       (rst),
      .bus       (if16),
      .stall_cnt (stall16),
      .flush_cnt (flush16)
   );

   pipe_latch #(.WIDTH(64), .NOP(NOP4), .CNT_W(4)) u_dut4 (
      .CLK       (clk),
      .RST       (rst),
      .bus       (if4),
      .stall_cnt (stall4),
      .flush_cnt (flush4)
   );

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic check_all();
      logic [63:0] exp_dout16, exp_dout4;
      exp_dout16 = (mq.size() > 0) ? mq[0] : NOP16;
      exp_dout4  = (mq.size() > 0) ? mq[0] : NOP4;
      check("out_valid16", 64'(if16.out_valid), 64'(mq.size() > 0));
      check("in_ready16", 64'(if16.in_ready), 64'(mq.size() < 2));
      check("dout16", if16.dout, exp_dout16);
      check("stall16", 64'(stall16), 64'(m_stall16));
      check("flush16", 64'(flush16), 64'(m_flush16));
      check("out_valid4", 64'(if4.out_valid), 64'(mq.size() > 0));
      check("in_ready4", 64'(if4.in_ready), 64'(mq.size() < 2));
      check("dout4", if4.dout, exp_dout4);
      check("stall4", 64'(stall4), 64'(m_stall4));
      check("flush4", 64'(flush4), 64'(m_flush4));
   endtask

   // Drive one cycle of stimulus (called just after a falling edge), advance the model at
   // the rising edge, then check every output at the next falling edge.
   task automatic cycle(input logic r, input logic iv, input logic [63:0] d, input logic fl,
                        input logic ordy);
      bit accept, emit;
      rst            = r;
      if16.in_valid  = iv;
      if16.din       = d;
      if16.flush     = fl;
      if16.out_ready = ordy;
      if4.in_valid   = iv;
      if4.din        = d;
      if4.flush      = fl;
      if4.out_ready  = ordy;
      accept = iv && (mq.size() < 2);
      emit   = (mq.size() > 0) && ordy;
      @(posedge clk);
      if (r) begin
         mq.delete();
         m_stall16 = 0;
         m_flush16 = 0;
         m_stall4  = 0;
         m_flush4  = 0;
      end else begin
         if (mq.size() > 0 && !ordy) begin
            if (m_stall16 < 65535) m_stall16++;
            if (m_stall4 < 15) m_stall4++;
         end
         if (fl && mq.size() > 0) begin
            if (m_flush16 < 65535) m_flush16++;
            if (m_flush4 < 15) m_flush4++;
         end
         if (emit) void'(mq.pop_front());
         if (accept) mq.push_back(d);
         if (fl) mq.delete();
      end
      @(negedge clk);
      check_all();
   endtask

   initial begin
      m_stall16 = 0;
      m_flush16 = 0;
      m_stall4  = 0;
      m_flush4  = 0;
      @(negedge clk);
      cycle(1'b1, 1'b0, 64'h0, 1'b0, 1'b0);
      cycle(1'b1, 1'b0, 64'h0, 1'b0, 1'b0);

      // Streaming 1..8 at full throughput.
      for (int i = 1; i <= 8; i++) cycle(1'b0, 1'b1, 64'(i), 1'b0, 1'b1);
      cycle(1'b0, 1'b0, 64'h0, 1'b0, 1'b1);
      check("stream_stall_zero", 64'(stall16), 64'h0);

      // Back-pressure into the skid register, then drain in order.
      cycle(1'b0, 1'b1, 64'hA, 1'b0, 1'b0);
      cycle(1'b0, 1'b1, 64'hB, 1'b0, 1'b0);
      check("skid_in_ready_low", 64'(if16.in_ready), 64'h0);
      check("skid_head_is_a", if16.dout, 64'hA);
      cycle(1'b0, 1'b0, 64'h0, 1'b0, 1'b1);
      check("drain_second_is_b", if16.dout, 64'hB);
      cycle(1'b0, 1'b0, 64'h0, 1'b0, 1'b1);

      // Flush while in SKID with a new beat offered.
      cycle(1'b0, 1'b1, 64'hA1, 1'b0, 1'b0);
      cycle(1'b0, 1'b1, 64'hB1, 1'b0, 1'b0);
      cycle(1'b0, 1'b1, 64'hC1, 1'b1, 1'b0);
      check("flush_skid_cnt", 64'(flush16), 64'h1);
      check("flush_skid_dout_nop", if16.dout, 64'h0);

      // Flush while empty is a no-op for state and counter.
      cycle(1'b0, 1'b0, 64'h0, 1'b1, 1'b0);
      check("flush_empty_cnt", 64'(flush16), 64'h1);

      // Hold a valid entry for 20 back-pressure cycles; 4-bit counter saturates.
      cycle(1'b0, 1'b1, 64'h77, 1'b0, 1'b0);
      for (int i = 0; i < 20; i++) cycle(1'b0, 1'b0, 64'h0, 1'b0, 1'b0);
      check("stall4_saturated", 64'(stall4), 64'd15);

      // Reset mid-stream together with flush and transfers.
      cycle(1'b0, 1'b1, 64'h55, 1'b0, 1'b1);
      cycle(1'b1, 1'b1, 64'h66, 1'b1, 1'b1);
      check("rst_out_valid", 64'(if16.out_valid), 64'h0);
      check("rst_flush_cnt", 64'(flush16), 64'h0);

      // Random traffic.
      for (int i = 0; i < 400; i++) begin
         cycle(($urandom_range(0, 59) == 0), 1'($urandom_range(0, 3) != 0),
               {$urandom, $urandom}, ($urandom_range(0, 11) == 0),
               1'($urandom_range(0, 2) != 0));
      end

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
